// File: rtl/act_mem_writeback_packer_pkg.sv
// Shared parameters and FSM state encoding for the activation-memory writeback packer.
package act_mem_writeback_packer_pkg;

  // Bytes per activation-memory word.
  localparam int unsigned N_DIM_ARRAY             = 8;
  // Bits per quantized activation.
  localparam int unsigned ACT_DATA_WIDTH          = 8;
  // Width of an activation-memory word index.
  localparam int unsigned INPUT_CHANNEL_ADDR_SIZE = 16;

  // Packer FSM state encoding.
  typedef logic [1:0] wb_state_t;

  localparam wb_state_t StIdle  = 2'd0;
  localparam wb_state_t StPack  = 2'd1;
  localparam wb_state_t StFlush = 2'd2;
  localparam wb_state_t StDone  = 2'd3;

endpackage

// File: rtl/act_mem_writeback_packer.sv
// Packs a stream of quantized activations into full activation-memory words and issues
// one write per word at consecutive word indices starting from base_word.
module act_mem_writeback_packer #(
  parameter int unsigned N_DIM_ARRAY    = act_mem_writeback_packer_pkg::N_DIM_ARRAY,
  parameter int unsigned ACT_DATA_WIDTH = act_mem_writeback_packer_pkg::ACT_DATA_WIDTH,
  parameter int unsigned ADDR_W         = act_mem_writeback_packer_pkg::INPUT_CHANNEL_ADDR_SIZE
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_word,
  input  logic                                in_valid,
  input  logic [ACT_DATA_WIDTH-1:0]           in_data,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic                                wr_en,
  output logic [ADDR_W-1:0]                   wr_addr_input,
  output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] wr_input_word,
  output logic                                busy,
  output logic                                done
);

  import act_mem_writeback_packer_pkg::*;

  localparam int unsigned WordW = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam int unsigned LaneW = (N_DIM_ARRAY > 1) ? $clog2(N_DIM_ARRAY) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(N_DIM_ARRAY - 1);

  wb_state_t          state_q, state_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic [WordW-1:0]   pack_q, pack_d;
  logic [WordW-1:0]   word_q, word_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
  // Set when in_last closed a partial word that still has to be issued from FLUSH.
  logic               flush_pend_q, flush_pend_d;

  logic               accept;
  logic [WordW-1:0]   pack_ins;

  assign in_ready = (state_q == StPack);
  assign accept   = in_valid && in_ready;

  // Packing register with the current beat dropped into its lane.
  always_comb begin
    pack_ins = pack_q;
    pack_ins[lane_q*ACT_DATA_WIDTH +: ACT_DATA_WIDTH] = in_data;
  end

  // Next-state logic: FSM sequencing, lane packing and word issue.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    word_d       = word_q;
    wr_en_d      = 1'b0;
    addr_d       = addr_q;
    next_addr_d  = next_addr_q;
    flush_pend_d = flush_pend_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StPack;
          next_addr_d  = base_word;
          lane_d       = '0;
          pack_d       = '0;
          flush_pend_d = 1'b0;
        end
      end
      StPack: begin
        if (accept) begin
          if (lane_q == LastLane) begin
            // Full word moves to the output register, so packing continues without a bubble.
            word_d      = pack_ins;
            wr_en_d     = 1'b1;
            addr_d      = next_addr_q;
            next_addr_d = next_addr_q + 1'b1;
            lane_d      = '0;
            pack_d      = '0;
          end else begin
            pack_d = pack_ins;
            lane_d = lane_q + 1'b1;
          end
          if (in_last) begin
            state_d      = StFlush;
            flush_pend_d = (lane_q != LastLane);
          end
        end
      end
      StFlush: begin
        if (flush_pend_q) begin
          // Unfilled lanes are already zero because pack_q is cleared at every word start.
          word_d       = pack_q;
          wr_en_d      = 1'b1;
          addr_d       = next_addr_q;
          next_addr_d  = next_addr_q + 1'b1;
          lane_d       = '0;
          pack_d       = '0;
          flush_pend_d = 1'b0;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; an asynchronous reset drops any partially packed word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      lane_q       <= '0;
      pack_q       <= '0;
      word_q       <= '0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      next_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      word_q       <= word_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      next_addr_q  <= next_addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr_input = addr_q;
  assign wr_input_word = word_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_act_mem_writeback_packer.sv
// Directed bench for the writeback packer: fixed jobs with hand-computed words and addresses.
module tb_act_mem_writeback_packer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_word;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr_input;
  logic [63:0] wr_input_word;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Write and done log gathered away from the active edge.
  logic [15:0] wa_q[$];
  logic [63:0] ww_q[$];
  int          wc_q[$];
  int          dc_q[$];

  logic [63:0] ref_words[8];

  act_mem_writeback_packer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_word     (base_word),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr_input (wr_addr_input),
    .wr_input_word (wr_input_word),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr_input);
      ww_q.push_back(wr_input_word);
      wc_q.push_back(cyc);
    end
    if (done) dc_q.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    ww_q.delete();
    wc_q.delete();
    dc_q.delete();
  endtask

  task automatic start_job(input logic [15:0] base);
    start     = 1'b1;
    base_word = base;
    @(posedge clk); #1;
    start     = 1'b0;
    base_word = 16'h0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      n_total++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (dc_q.size() == 0 && g < 300) begin
      @(posedge clk); #2;
      g++;
    end
    check_eq("done_seen", 64'(dc_q.size() != 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    base_word = 16'h0;
    in_valid  = 1'b0;
    in_data   = 8'h0;
    in_last   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("rst_addr", 64'(wr_addr_input), 64'd0);
    check_eq("rst_word", wr_input_word, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Two full words back to back.
    clear_log();
    start_job(16'h0010);
    check_eq("t1_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 16; i++) send(8'(i), i == 16);
    wait_done();
    check_eq("t1_nwr", 64'(wa_q.size()), 64'd2);
    check_eq("t1_addr0", 64'(wa_q[0]), 64'h0010);
    check_eq("t1_word0", ww_q[0], 64'h0807060504030201);
    check_eq("t1_addr1", 64'(wa_q[1]), 64'h0011);
    check_eq("t1_word1", ww_q[1], 64'h100F0E0D0C0B0A09);
    check_eq("t1_spacing", 64'(wc_q[1] - wc_q[0]), 64'd8);
    check_eq("t1_done_lat", 64'(dc_q[0] - wc_q[1]), 64'd1);
    check_eq("t1_ndone", 64'(dc_q.size()), 64'd1);
    check_eq("t1_busy_end", 64'(busy), 64'd0);

    // Partial word zero-filled on in_last.
    clear_log();
    start_job(16'h0100);
    send(8'h7F, 1'b0);
    send(8'h80, 1'b0);
    send(8'hFF, 1'b1);
    wait_done();
    check_eq("t2_nwr", 64'(wa_q.size()), 64'd1);
    check_eq("t2_addr", 64'(wa_q[0]), 64'h0100);
    check_eq("t2_word", ww_q[0], 64'h0000000000FF807F);
    check_eq("t2_done_lat", 64'(dc_q[0] - wc_q[0]), 64'd1);

    // Address wrap.
    clear_log();
    start_job(16'hFFFF);
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), i == 15);
    wait_done();
    check_eq("t3_nwr", 64'(wa_q.size()), 64'd2);
    check_eq("t3_addr0", 64'(wa_q[0]), 64'hFFFF);
    check_eq("t3_addr1", 64'(wa_q[1]), 64'h0000);
    check_eq("t3_word1", ww_q[1], 64'h2F2E2D2C2B2A2928);

    // Random in_valid gaps over 64 beats against a reference packing.
    clear_log();
    for (int w = 0; w < 8; w++) ref_words[w] = 64'h0;
    start_job(16'h0040);
    for (int i = 0; i < 64; i++) begin
      int gap;
      logic [7:0] d;
      gap = $urandom_range(0, 2);
      d   = 8'($urandom);
      ref_words[i / 8][(i % 8) * 8 +: 8] = d;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
      send(d, i == 63);
    end
    wait_done();
    check_eq("t4_nwr", 64'(wa_q.size()), 64'd8);
    for (int w = 0; w < 8; w++) begin
      check_eq($sformatf("t4_addr%0d", w), 64'(wa_q[w]), 64'(16'h0040 + w));
      check_eq($sformatf("t4_word%0d", w), ww_q[w], ref_words[w]);
    end

    // Reset mid-job.
    clear_log();
    start_job(16'h0200);
    for (int i = 0; i < 5; i++) send(8'(8'h90 + i), 1'b0);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("t5_rst_busy", 64'(busy), 64'd0);
    check_eq("t5_rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("t5_rst_addr", 64'(wr_addr_input), 64'd0);
    check_eq("t5_rst_word", wr_input_word, 64'd0);
    check_eq("t5_rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 8'h55;
    repeat (10) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("t5_no_wr", 64'(wa_q.size()), 64'd0);
    check_eq("t5_idle_busy", 64'(busy), 64'd0);
    start_job(16'h0300);
    for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), i == 7);
    wait_done();
    check_eq("t5_nwr", 64'(wa_q.size()), 64'd1);
    check_eq("t5_addr", 64'(wa_q[0]), 64'h0300);
    check_eq("t5_word", ww_q[0], 64'hA7A6A5A4A3A2A1A0);

    // Start while busy is ignored.
    clear_log();
    start_job(16'h0400);
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1'b0);
    start_job(16'h0500);
    check_eq("t6_busy_mid", 64'(busy), 64'd1);
    for (int i = 4; i < 16; i++) send(8'(8'h40 + i), i == 15);
    wait_done();
    repeat (10) @(posedge clk);
    #1;
    check_eq("t6_nwr", 64'(wa_q.size()), 64'd2);
    check_eq("t6_addr0", 64'(wa_q[0]), 64'h0400);
    check_eq("t6_word0", ww_q[0], 64'h4746454443424140);
    check_eq("t6_addr1", 64'(wa_q[1]), 64'h0401);
    check_eq("t6_word1", ww_q[1], 64'h4F4E4D4C4B4A4948);
    check_eq("t6_ndone", 64'(dc_q.size()), 64'd1);
    check_eq("t6_busy_end", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/act_mem_writeback_packer.md
ACT_MEM_WRITEBACK_PACKER -- requirements
Module: act_mem_writeback_packer

Interface
REQ-001 SHALL have parameter N_DIM_ARRAY, default 8, bytes per activation-memory word.
REQ-002 SHALL have parameter ACT_DATA_WIDTH, default 8, bits per activation.
REQ-003 SHALL have parameter ADDR_W, default 16, word-index width.
REQ-004 SHALL have port clk  in  1  clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a job; ignored unless IDLE.
REQ-007 SHALL have port base_word  in  ADDR_W  first word index of the job, sampled on start.
REQ-008 SHALL have port in_valid  in  1  an output activation is offered.
REQ-009 SHALL have port in_data  in  ACT_DATA_WIDTH  signed quantized activation.
REQ-010 SHALL have port in_last  in  1  marks the final activation of the job.
REQ-011 SHALL have port in_ready  out  1  the packer accepts in_data this cycle.
REQ-012 SHALL have port wr_en  out  1  write strobe towards activation memory.
REQ-013 SHALL have port wr_addr_input  out  ADDR_W  word index; memory adds output pointer offset.
REQ-014 SHALL have port wr_input_word  out  N_DIM_ARRAY*ACT_DATA_WIDTH  packed word.
REQ-015 SHALL have port busy  out  1  high from accepted start until done.
REQ-016 SHALL have port done  out  1  one-cycle pulse after the last word is written.

Function
REQ-017 SHALL implement FSM IDLE -> PACK on start; PACK -> FLUSH on an accepted beat with in_last; FLUSH -> DONE after the final word is issued; DONE -> IDLE after one cycle.
REQ-018 SHALL accept a beat when in_valid && in_ready; in_ready = 1 only in PACK and only when the output register is not holding an unwritten full word.
REQ-019 SHALL place the k-th accepted byte of a word in lane k (bits k*8+7:k*8), lane 0 first; lane counter wraps N_DIM_ARRAY-1 -> 0.
REQ-020 SHALL register a completed word into wr_input_word and assert wr_en for exactly one cycle, one cycle after the beat filling lane N_DIM_ARRAY-1 (latency 1).
REQ-021 SHALL drive wr_addr_input = base_word for the first word and increment by 1 per issued word, wrapping modulo 2^ADDR_W.
REQ-022 SHALL, when in_last arrives with a partial word, zero-fill unfilled lanes and issue that word in FLUSH; in_last on lane N_DIM_ARRAY-1 issues no extra word.
REQ-023 SHALL sustain one beat per cycle with no bubble at word boundaries (packing register and output register are separate).
REQ-024 SHALL hold wr_input_word stable and keep wr_en = 0 except during issue cycles.
REQ-025 SHALL ignore start while busy and ignore in_valid outside PACK.
REQ-026 SHALL pulse done in DONE, in the cycle after the last wr_en.

Reset
REQ-027 SHALL, on reset low, immediately force state IDLE, in_ready = 0, wr_en = 0, wr_addr_input = 0, wr_input_word = 0, busy = 0, done = 0, lane counter = 0.
REQ-028 SHALL discard any partially packed word when reset asserts mid-job; no write is issued after reset release until a new start.

Structure
REQ-029 SHALL take N_DIM_ARRAY, ACT_DATA_WIDTH, INPUT_CHANNEL_ADDR_SIZE and the FSM state enum from the shared parameters package.
REQ-030 SHALL be a single module with no sub-modules; output feeds activation_memory wr_en/wr_addr_input/wr_input_word directly.

Verification
REQ-031 SHALL verify: base_word=0x0010, 16 back-to-back beats 0x01..0x10, last on 16th -> two wr_en pulses, addr 0x0010 word 0x0807060504030201, addr 0x0011 word 0x100F0E0D0C0B0A09, done one cycle after the second.
REQ-032 SHALL verify: 3 beats 0x7F,0x80,0xFF with last on third -> one write of 0x0000000000FF807F, then done.
REQ-033 SHALL verify: base_word=0xFFFF, 16 beats -> writes at 0xFFFF then 0x0000.
REQ-034 SHALL verify: random in_valid gaps over 64 beats -> eight words, contents equal to the reference packing, addresses consecutive, no lost or duplicated bytes.
REQ-035 SHALL verify: reset asserted after 5 beats of a job -> outputs reset immediately; after release, no wr_en until a new start; new job of 8 beats writes correctly at its base_word.
REQ-036 SHALL verify: start pulsed while busy -> ignored; busy, addresses and done follow only the first job.
